reorder_buffer: RTL and testbench

//  In-order retirement scheduler for the tagged register file. Dispatch allocates a slot per instruction
//  (tag = slot+1, tag 0 = "no dependency"). Execution units write results back by tag; head entries retire
//  in order, one per cycle, as a write on the regfile wEn/wId/wAddr/wData port. A retiring mispredict flushes all.

---
 rtl/reorder_buffer_pkg.sv | 39 +++
 rtl/reorder_buffer_if.sv | 50 +++++
 rtl/reorder_buffer_bypass.sv | 34 +++
 rtl/reorder_buffer.sv | 135 +++++++++++++
 tb/tb_reorder_buffer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared sizes, types and tag helpers for the reorder buffer.
package reorder_buffer_pkg;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned PTR_W  = 4;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [PTR_W:0]    cnt_t;
    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_W-1:0]  reg_addr_t;

    typedef struct packed {
        logic      valid;
        logic      done;
        logic      has_dest;
        reg_addr_t dest;
        data_t     data;
        logic      mispred;
        data_t     target;
    } slot_t;

    // Tag 0 means "no dependency"; tags above DEPTH name no slot.
    function automatic logic tag_in_range(tag_t tag);
        return (tag != '0) && (tag <= tag_t'(DEPTH));
    endfunction

    function automatic ptr_t tag_to_idx(tag_t tag);
        return ptr_t'(tag - tag_t'(1));
    endfunction

    function automatic tag_t idx_to_tag(ptr_t idx);
        return tag_t'(idx) + tag_t'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback, operand-query and commit signals of the reorder buffer.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic      alloc_valid_i;
    logic      alloc_has_dest_i;
    reg_addr_t alloc_dest_i;
    logic      alloc_ready_o;
    tag_t      alloc_tag_o;

    logic      wb_valid_i;
    tag_t      wb_tag_i;
    data_t     wb_data_i;
    logic      wb_mispred_i;
    data_t     wb_target_i;

    tag_t      q1_tag_i;
    tag_t      q2_tag_i;
    logic      q1_rdy_o;
    logic      q2_rdy_o;
    data_t     q1_data_o;
    data_t     q2_data_o;

    logic      commit_wEn_o;
    tag_t      commit_wId_o;
    reg_addr_t commit_wAddr_o;
    data_t     commit_wData_o;
    logic      flush_o;
    data_t     flush_pc_o;
    cnt_t      count_o;

    modport master (
        output alloc_valid_i, alloc_has_dest_i, alloc_dest_i,
        output wb_valid_i, wb_tag_i, wb_data_i, wb_mispred_i, wb_target_i,
        output q1_tag_i, q2_tag_i,
        input  alloc_ready_o, alloc_tag_o, q1_rdy_o, q2_rdy_o, q1_data_o, q2_data_o,
        input  commit_wEn_o, commit_wId_o, commit_wAddr_o, commit_wData_o,
        input  flush_o, flush_pc_o, count_o
    );

    modport slave (
        input  alloc_valid_i, alloc_has_dest_i, alloc_dest_i,
        input  wb_valid_i, wb_tag_i, wb_data_i, wb_mispred_i, wb_target_i,
        input  q1_tag_i, q2_tag_i,
        output alloc_ready_o, alloc_tag_o, q1_rdy_o, q2_rdy_o, q1_data_o, q2_data_o,
        output commit_wEn_o, commit_wId_o, commit_wAddr_o, commit_wData_o,
        output flush_o, flush_pc_o, count_o
    );

endinterface

// File: rtl/reorder_buffer_bypass.sv
// Operand lookup by tag: same-cycle writeback forward first, then finished slots.
module reorder_buffer_bypass
    import reorder_buffer_pkg::*;
(
    input  tag_t             q_tag_i,
    input  logic             wb_valid_i,
    input  tag_t             wb_tag_i,
    input  data_t            wb_data_i,
    input  logic [DEPTH-1:0] slot_valid_i,
    input  logic [DEPTH-1:0] slot_done_i,
    input  data_t            slot_data_i [DEPTH],
    output logic             q_rdy_o,
    output data_t            q_data_o
);

    ptr_t idx;

    // Resolve the queried tag to a ready flag and value.
    always_comb begin
        q_rdy_o  = 1'b0;
        q_data_o = '0;
        idx      = tag_to_idx(q_tag_i);
        if (q_tag_i != '0) begin
            if (wb_valid_i && (wb_tag_i == q_tag_i)) begin
                q_rdy_o  = 1'b1;
                q_data_o = wb_data_i;
            end else if (tag_in_range(q_tag_i) && slot_valid_i[idx] && slot_done_i[idx]) begin
                q_rdy_o  = 1'b1;
                q_data_o = slot_data_i[idx];
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates slots at dispatch, collects results by tag,
// retires one head entry per cycle to the regfile and flushes on a mispredicted retire.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input logic             clk,
    input logic             rst,
    input logic             rdy,
    reorder_buffer_if.slave bus
);

    slot_t     slots_q [DEPTH];
    ptr_t      head_q;
    ptr_t      tail_q;
    cnt_t      count_q;
    logic      commit_wen_q;
    tag_t      commit_wid_q;
    reg_addr_t commit_waddr_q;
    data_t     commit_wdata_q;
    logic      flush_q;
    data_t     flush_pc_q;

    slot_t            head_slot;
    logic             alloc_ready;
    logic             alloc_fire;
    logic             retire_fire;
    logic             flush_fire;
    logic             wb_hit;
    ptr_t             wb_idx;
    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] slot_done;
    data_t            slot_data [DEPTH];

    // Handshake decode, all from start-of-cycle state.
    always_comb begin
        head_slot   = slots_q[head_q];
        retire_fire = rdy & head_slot.valid & head_slot.done;
        flush_fire  = retire_fire & head_slot.mispred;
        // Allocation is blocked during the flush pulse so the redirected stream starts clean.
        alloc_ready = !rst && (count_q < cnt_t'(DEPTH)) && !flush_q;
        alloc_fire  = rdy & bus.alloc_valid_i & alloc_ready;
        wb_idx      = tag_to_idx(bus.wb_tag_i);
        wb_hit      = rdy & bus.wb_valid_i & tag_in_range(bus.wb_tag_i) & slots_q[wb_idx].valid;
        for (int i = 0; i < DEPTH; i++) begin
            slot_valid[i] = slots_q[i].valid;
            slot_done[i]  = slots_q[i].done;
            slot_data[i]  = slots_q[i].data;
        end
    end

    // Slot array, pointers, count and registered commit/flush outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_wen_q   <= 1'b0;
            commit_wid_q   <= '0;
            commit_waddr_q <= '0;
            commit_wdata_q <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else if (rdy) begin
            commit_wen_q <= retire_fire & head_slot.has_dest & (head_slot.dest != '0);
            flush_q      <= flush_fire;
            if (retire_fire) begin
                commit_wid_q   <= idx_to_tag(head_q);
                commit_waddr_q <= head_slot.dest;
                commit_wdata_q <= head_slot.data;
            end
            if (flush_fire) begin
                flush_pc_q <= head_slot.target;
                for (int i = 0; i < DEPTH; i++) slots_q[i].valid <= 1'b0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                // A free tail slot is never valid, so wb and alloc never touch the same slot.
                if (wb_hit) begin
                    slots_q[wb_idx].done    <= 1'b1;
                    slots_q[wb_idx].data    <= bus.wb_data_i;
                    slots_q[wb_idx].mispred <= bus.wb_mispred_i;
                    slots_q[wb_idx].target  <= bus.wb_target_i;
                end
                if (alloc_fire) begin
                    slots_q[tail_q] <= '{valid: 1'b1, done: 1'b0, has_dest: bus.alloc_has_dest_i,
                                         dest: bus.alloc_dest_i, data: '0, mispred: 1'b0,
                                         target: '0};
                    tail_q <= tail_q + ptr_t'(1);
                end
                if (retire_fire) begin
                    slots_q[head_q].valid <= 1'b0;
                    head_q <= head_q + ptr_t'(1);
                end
                count_q <= count_q + cnt_t'(alloc_fire) - cnt_t'(retire_fire);
            end
        end
    end

    assign bus.alloc_ready_o  = alloc_ready;
    assign bus.alloc_tag_o    = idx_to_tag(tail_q);
    assign bus.commit_wEn_o   = commit_wen_q;
    assign bus.commit_wId_o   = commit_wid_q;
    assign bus.commit_wAddr_o = commit_waddr_q;
    assign bus.commit_wData_o = commit_wdata_q;
    assign bus.flush_o        = flush_q;
    assign bus.flush_pc_o     = flush_pc_q;
    assign bus.count_o        = count_q;

    reorder_buffer_bypass u_bypass_q1 (
        .q_tag_i      (bus.q1_tag_i),
        .wb_valid_i   (bus.wb_valid_i),
        .wb_tag_i     (bus.wb_tag_i),
        .wb_data_i    (bus.wb_data_i),
        .slot_valid_i (slot_valid),
        .slot_done_i  (slot_done),
        .slot_data_i  (slot_data),
        .q_rdy_o      (bus.q1_rdy_o),
        .q_data_o     (bus.q1_data_o)
    );

    reorder_buffer_bypass u_bypass_q2 (
        .q_tag_i      (bus.q2_tag_i),
        .wb_valid_i   (bus.wb_valid_i),
        .wb_tag_i     (bus.wb_tag_i),
        .wb_data_i    (bus.wb_data_i),
        .slot_valid_i (slot_valid),
        .slot_done_i  (slot_done),
        .slot_data_i  (slot_data),
        .q_rdy_o      (bus.q2_rdy_o),
        .q_data_o     (bus.q2_data_o)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic, all checked against
// a queue-of-entries reference model of in-order retirement.
module tb_reorder_buffer;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    always #5 clk = ~clk;

    reorder_buffer_if bus ();

    reorder_buffer dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    typedef struct {
        int          tag;
        bit          has_dest;
        int          dest;
        bit          done;
        logic [31:0] data;
        bit          mis;
        logic [31:0] tgt;
    } ent_t;

    // Reference model: in-flight entries, oldest first.
    ent_t        rob[$];
    int          m_tail;
    bit          e_wen;
    int          e_wid;
    int          e_waddr;
    logic [31:0] e_wdata;
    bit          e_flush;
    logic [31:0] e_fpc;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic void model_query(input int t, output bit r, output logic [31:0] d);
        r = 1'b0;
        d = '0;
        if (t == 0) return;
        if (bus.wb_valid_i && int'(bus.wb_tag_i) == t) begin
            r = 1'b1;
            d = bus.wb_data_i;
            return;
        end
        foreach (rob[i]) begin
            if (rob[i].tag == t && rob[i].done) begin
                r = 1'b1;
                d = rob[i].data;
            end
        end
    endfunction

    function automatic void model_reset();
        rob.delete();
        m_tail  = 0;
        e_wen   = 1'b0;
        e_wid   = 0;
        e_waddr = 0;
        e_wdata = '0;
        e_flush = 1'b0;
        e_fpc   = '0;
    endfunction

    function automatic void model_step();
        bit   ready, retire, alloc;
        ent_t e;
        if (rst) begin
            model_reset();
            return;
        end
        if (!rdy) return;
        ready  = (rob.size() < 16) && !e_flush;
        retire = (rob.size() > 0) && rob[0].done;
        alloc  = bus.alloc_valid_i && ready;
        e_wen   = retire && rob[0].has_dest && (rob[0].dest != 0);
        e_flush = retire && rob[0].mis;
        if (retire) begin
            e_wid   = rob[0].tag;
            e_waddr = rob[0].dest;
            e_wdata = rob[0].data;
            if (rob[0].mis) e_fpc = rob[0].tgt;
        end
        if (bus.wb_valid_i) begin
            foreach (rob[i]) begin
                if (rob[i].tag == int'(bus.wb_tag_i)) begin
                    rob[i].done = 1'b1;
                    rob[i].data = bus.wb_data_i;
                    rob[i].mis  = bus.wb_mispred_i;
                    rob[i].tgt  = bus.wb_target_i;
                end
            end
        end
        if (e_flush) begin
            rob.delete();
            m_tail = 0;
        end else begin
            if (retire) void'(rob.pop_front());
            if (alloc) begin
                e.tag      = m_tail + 1;
                e.has_dest = bus.alloc_has_dest_i;
                e.dest     = int'(bus.alloc_dest_i);
                e.done     = 1'b0;
                e.data     = '0;
                e.mis      = 1'b0;
                e.tgt      = '0;
                rob.push_back(e);
                m_tail = (m_tail + 1) % 16;
            end
        end
    endfunction

    // Called at a falling edge with inputs driven; checks outputs, advances the model,
    // and returns at the next falling edge.
    task automatic cycle();
        bit          r;
        logic [31:0] d;
        #1;
        chk("alloc_ready", bus.alloc_ready_o, (!rst && rob.size() < 16 && !e_flush));
        chk("alloc_tag", bus.alloc_tag_o, m_tail + 1);
        chk("count", bus.count_o, rob.size());
        chk("commit_wen", bus.commit_wEn_o, e_wen);
        if (e_wen) begin
            chk("commit_wid", bus.commit_wId_o, e_wid);
            chk("commit_waddr", bus.commit_wAddr_o, e_waddr);
            chk("commit_wdata", bus.commit_wData_o, e_wdata);
        end
        chk("flush", bus.flush_o, e_flush);
        if (e_flush) chk("flush_pc", bus.flush_pc_o, e_fpc);
        model_query(int'(bus.q1_tag_i), r, d);
        chk("q1_rdy", bus.q1_rdy_o, r);
        chk("q1_data", bus.q1_data_o, d);
        model_query(int'(bus.q2_tag_i), r, d);
        chk("q2_rdy", bus.q2_rdy_o, r);
        chk("q2_data", bus.q2_data_o, d);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst                  = 1'b0;
        rdy                  = 1'b1;
        bus.alloc_valid_i    = 1'b0;
        bus.alloc_has_dest_i = 1'b0;
        bus.alloc_dest_i     = '0;
        bus.wb_valid_i       = 1'b0;
        bus.wb_tag_i         = '0;
        bus.wb_data_i        = '0;
        bus.wb_mispred_i     = 1'b0;
        bus.wb_target_i      = '0;
        bus.q1_tag_i         = '0;
        bus.q2_tag_i         = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic do_alloc(input int dest);
        bus.alloc_valid_i    = 1'b1;
        bus.alloc_has_dest_i = 1'b1;
        bus.alloc_dest_i     = 5'(dest);
        cycle();
        bus.alloc_valid_i    = 1'b0;
    endtask

    task automatic do_wb(input int tag, input logic [31:0] data, input bit mis,
                         input logic [31:0] tgt);
        bus.wb_valid_i   = 1'b1;
        bus.wb_tag_i     = 5'(tag);
        bus.wb_data_i    = data;
        bus.wb_mispred_i = mis;
        bus.wb_target_i  = tgt;
        cycle();
        bus.wb_valid_i   = 1'b0;
        bus.wb_mispred_i = 1'b0;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: reset, three allocs
        do_reset();
        do_alloc(1);
        do_alloc(2);
        do_alloc(3);
        chk("t1_count", bus.count_o, 3);
        chk("t1_no_commit", bus.commit_wEn_o, 0);

        // 2: out-of-order writeback, in-order commit
        do_wb(2, 32'hA, 1'b0, '0);
        do_wb(1, 32'hB, 1'b0, '0);
        cycle();
        chk("t2_wen1", bus.commit_wEn_o, 1);
        chk("t2_wid1", bus.commit_wId_o, 1);
        chk("t2_wdata1", bus.commit_wData_o, 32'hB);
        cycle();
        chk("t2_wid2", bus.commit_wId_o, 2);
        chk("t2_waddr2", bus.commit_wAddr_o, 2);
        chk("t2_wdata2", bus.commit_wData_o, 32'hA);

        // 3: fill, then retire with allocs pending; tail wraps and tag 1 is reused
        do_reset();
        for (int k = 0; k < 20 && rob.size() < 16; k++) do_alloc(k % 32);
        chk("t3_full_ready", bus.alloc_ready_o, 0);
        chk("t3_wrap_tag", bus.alloc_tag_o, 1);
        do_wb(1, 32'h11, 1'b0, '0);
        chk("t3_cnt_full", bus.count_o, 16);
        bus.wb_valid_i = 1'b1;
        bus.wb_tag_i   = 5'd2;
        bus.wb_data_i  = 32'h22;
        do_alloc(9);
        bus.wb_valid_i = 1'b0;
        chk("t3_cnt_after_retire", bus.count_o, 15);
        do_alloc(10);
        chk("t3_cnt_retire_alloc", bus.count_o, 15);
        chk("t3_wid2", bus.commit_wId_o, 2);
        chk("t3_next_tag", bus.alloc_tag_o, 2);

        // 4: mispredicted head flushes younger finished entries
        do_reset();
        for (int k = 0; k < 4; k++) do_alloc(4 + k);
        for (int k = 2; k <= 4; k++) do_wb(k, 32'(k), 1'b0, '0);
        do_wb(1, 32'h77, 1'b1, 32'h100);
        cycle();
        chk("t4_flush", bus.flush_o, 1);
        chk("t4_flush_pc", bus.flush_pc_o, 32'h100);
        chk("t4_count", bus.count_o, 0);
        repeat (3) cycle();

        // 5: operand forward from same-cycle writeback
        for (int k = 0; k < 3; k++) do_alloc(k + 1);
        bus.q1_tag_i   = 5'd3;
        bus.q2_tag_i   = 5'd0;
        bus.wb_valid_i = 1'b1;
        bus.wb_tag_i   = 5'd3;
        bus.wb_data_i  = 32'h55;
        #1;
        chk("t5_q1_rdy", bus.q1_rdy_o, 1);
        chk("t5_q1_data", bus.q1_data_o, 32'h55);
        chk("t5_q2_rdy", bus.q2_rdy_o, 0);
        cycle();
        idle_inputs();
        bus.q1_tag_i = 5'd3;
        cycle();

        // 6: freeze mid-retire, then reset mid-stream
        do_wb(1, 32'h1, 1'b0, '0);
        do_wb(2, 32'h2, 1'b0, '0);
        rdy = 1'b0;
        repeat (4) cycle();
        rdy = 1'b1;
        do_alloc(6);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_rst_count", bus.count_o, 0);
        chk("t6_rst_wen", bus.commit_wEn_o, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst                  = ($urandom_range(0, 199) == 0);
            rdy                  = ($urandom_range(0, 9) != 0);
            bus.alloc_valid_i    = ($urandom_range(0, 9) < 6);
            bus.alloc_has_dest_i = ($urandom_range(0, 9) < 8);
            bus.alloc_dest_i     = 5'($urandom_range(0, 31));
            bus.wb_valid_i       = ($urandom_range(0, 9) < 6);
            if (rob.size() > 0 && $urandom_range(0, 9) < 8)
                bus.wb_tag_i = 5'(rob[$urandom_range(0, rob.size() - 1)].tag);
            else
                bus.wb_tag_i = 5'($urandom_range(0, 16));
            bus.wb_data_i    = $urandom;
            bus.wb_mispred_i = ($urandom_range(0, 24) == 0);
            bus.wb_target_i  = $urandom;
            bus.q1_tag_i     = ($urandom_range(0, 9) < 3) ? bus.wb_tag_i
                                                          : 5'($urandom_range(0, 16));
            bus.q2_tag_i     = 5'($urandom_range(0, 16));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
